// File: rtl/beatmap_scheduler.sv
// Beat-paced note scheduler: once per beat, grants one note lane round-robin and
// presents its byte to a ready/valid consumer; beats lost while a note is held are counted.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | not playing; beat counter parked at 0
// WAIT_BEAT | playing, waiting for the next beat_tick
// ARB       | one cycle: pick the next requesting lane after last_grant
// EMIT      | note_valid held until the consumer takes it
module beatmap_scheduler #(
    parameter int          NUM_LANES = 4,
    parameter logic [15:0] BEAT_DIV  = 16'd50000
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   stop,
    input  logic [NUM_LANES-1:0]   lane_req,
    input  logic [8*NUM_LANES-1:0] lane_data,
    output logic [NUM_LANES-1:0]   lane_adv,
    output logic                   note_valid,
    input  logic                   note_ready,
    output logic [1:0]             note_lane,
    output logic [7:0]             note_data,
    output logic                   beat_tick,
    output logic                   busy,
    output logic [7:0]             overrun_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT_BEAT, ARB, EMIT} state_t;

    state_t               state;
    logic [15:0]          beat_cnt;
    logic [1:0]           last_grant;
    logic                 found_hi, found_lo, found;
    logic [1:0]           win_hi, win_lo, win;
    logic [7:0]           win_data;
    logic [NUM_LANES-1:0] adv_vec;

    assign busy      = (state != IDLE);
    assign beat_tick = busy && (beat_cnt == BEAT_DIV - 16'd1);

    // Lanes above last_grant win first; otherwise wrap to the lowest requester.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = 2'd0;
        win_lo   = 2'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_req[i]) begin
                if (i > int'(last_grant) && !found_hi) begin
                    found_hi = 1'b1;
                    win_hi   = 2'(i);
                end
                if (!found_lo) begin
                    found_lo = 1'b1;
                    win_lo   = 2'(i);
                end
            end
        end
        win   = found_hi ? win_hi : win_lo;
        found = found_lo;
    end

    always_comb begin
        win_data = 8'd0;
        adv_vec  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (2'(i) == win) begin
                win_data   = lane_data[8*i +: 8];
                adv_vec[i] = 1'b1;
            end
        end
    end

    // The advance pulse must never escape while stop or reset is pulling us to IDLE.
    assign lane_adv = (resetn && !stop && state == ARB && found) ? adv_vec : '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            beat_cnt    <= 16'd0;
            last_grant  <= 2'(NUM_LANES - 1);
            note_valid  <= 1'b0;
            note_lane   <= 2'd0;
            note_data   <= 8'd0;
            overrun_cnt <= 8'd0;
        end else if (stop) begin
            state      <= IDLE;
            beat_cnt   <= 16'd0;
            note_valid <= 1'b0;
        end else begin
            if (state == IDLE || beat_tick)
                beat_cnt <= 16'd0;
            else
                beat_cnt <= beat_cnt + 16'd1;

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= WAIT_BEAT;
                        overrun_cnt <= 8'd0;
                        last_grant  <= 2'(NUM_LANES - 1);
                    end
                end
                WAIT_BEAT: begin
                    if (beat_tick)
                        state <= ARB;
                end
                ARB: begin
                    if (found) begin
                        note_data  <= win_data;
                        note_lane  <= win;
                        last_grant <= win;
                        note_valid <= 1'b1;
                        state      <= EMIT;
                    end else begin
                        state <= WAIT_BEAT;
                    end
                end
                EMIT: begin
                    if (beat_tick && overrun_cnt != 8'hFF)
                        overrun_cnt <= overrun_cnt + 8'd1;
                    if (note_ready) begin
                        note_valid <= 1'b0;
                        state      <= WAIT_BEAT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_beatmap_scheduler.sv
// Directed bench for beatmap_scheduler with BEAT_DIV=4, NUM_LANES=4.
module tb_beatmap_scheduler;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        stop;
    logic [3:0]  lane_req;
    logic [31:0] lane_data;
    logic [3:0]  lane_adv;
    logic        note_valid;
    logic        note_ready;
    logic [1:0]  note_lane;
    logic [7:0]  note_data;
    logic        beat_tick;
    logic        busy;
    logic [7:0]  overrun_cnt;

    int tests = 0;
    int fails = 0;
    int adv_n, valid_n, tick_n;

    beatmap_scheduler #(.NUM_LANES(4), .BEAT_DIV(16'd4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .stop       (stop),
        .lane_req   (lane_req),
        .lane_data  (lane_data),
        .lane_adv   (lane_adv),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_lane  (note_lane),
        .note_data  (note_data),
        .beat_tick  (beat_tick),
        .busy       (busy),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},    32'(busy),        32'd0);
        chk({tag, "_valid"},   32'(note_valid),  32'd0);
        chk({tag, "_lane"},    32'(note_lane),   32'd0);
        chk({tag, "_data"},    32'(note_data),   32'd0);
        chk({tag, "_adv"},     32'(lane_adv),    32'd0);
        chk({tag, "_tick"},    32'(beat_tick),   32'd0);
        chk({tag, "_overrun"}, 32'(overrun_cnt), 32'd0);
    endtask

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        lane_req   = 4'b0000;
        lane_data  = 32'd0;
        note_ready = 1'b0;
        cycles(2);
        chk_reset_outputs("reset");
        resetn = 1'b1;
        cyc();

        // Single lane, consumer always ready
        lane_req   = 4'b0001;
        lane_data  = {8'd0, 8'd0, 8'd0, 8'd100};
        note_ready = 1'b1;
        start      = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_tick", 32'(beat_tick), 32'd0);
        cycles(3);
        chk("tick_cnt3", 32'(beat_tick), 32'd1);
        cyc();
        chk("arb_adv", 32'(lane_adv), 32'd1);
        chk("arb_tick", 32'(beat_tick), 32'd0);
        cyc();
        chk("emit_valid", 32'(note_valid), 32'd1);
        chk("emit_data", 32'(note_data), 32'd100);
        chk("emit_lane", 32'(note_lane), 32'd0);
        chk("emit_adv", 32'(lane_adv), 32'd0);
        cyc();
        chk("taken_valid", 32'(note_valid), 32'd0);
        cyc();
        chk("tick2", 32'(beat_tick), 32'd1);
        cyc();
        chk("arb2_adv", 32'(lane_adv), 32'd1);

        // Round robin across four lanes from a fresh start
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_idle", 32'(busy), 32'd0);
        lane_req  = 4'b1111;
        lane_data = {8'd112, 8'd108, 8'd104, 8'd100};
        start     = 1'b1;
        cyc();
        start = 1'b0;
        cycles(4);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr_adv%0d", k), 32'(lane_adv), 32'(4'b0001 << (k % 4)));
            cyc();
            chk($sformatf("rr_lane%0d", k), 32'(note_lane), 32'(k % 4));
            chk($sformatf("rr_data%0d", k), 32'(note_data), 32'(100 + 4 * (k % 4)));
            cycles(3);
        end

        // Backpressure: one grant, note held, three beats lost
        stop = 1'b1;
        cyc();
        stop       = 1'b0;
        lane_req   = 4'b0001;
        lane_data  = {8'd0, 8'd0, 8'd0, 8'd100};
        note_ready = 1'b0;
        start      = 1'b1;
        cyc();
        start = 1'b0;
        cycles(4);
        chk("bp_adv", 32'(lane_adv), 32'd1);
        cyc();
        lane_data = {8'd0, 8'd0, 8'd0, 8'd55};
        adv_n = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (lane_adv != 4'd0) adv_n++;
        end
        chk("bp_adv_count", 32'(adv_n), 32'd0);
        chk("bp_valid", 32'(note_valid), 32'd1);
        chk("bp_data_stable", 32'(note_data), 32'd100);
        chk("bp_overrun", 32'(overrun_cnt), 32'd3);
        note_ready = 1'b1;
        cyc();
        chk("bp_release_valid", 32'(note_valid), 32'd0);
        chk("bp_release_busy", 32'(busy), 32'd1);
        chk("bp_release_overrun", 32'(overrun_cnt), 32'd3);

        // No requests for three beats; restart also clears overrun
        stop = 1'b1;
        cyc();
        stop     = 1'b0;
        lane_req = 4'b0000;
        start    = 1'b1;
        cyc();
        start = 1'b0;
        chk("restart_overrun", 32'(overrun_cnt), 32'd0);
        adv_n = 0; valid_n = 0; tick_n = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (lane_adv != 4'd0) adv_n++;
            if (note_valid) valid_n++;
            if (beat_tick) tick_n++;
        end
        chk("empty_adv", 32'(adv_n), 32'd0);
        chk("empty_valid", 32'(valid_n), 32'd0);
        chk("empty_ticks", 32'(tick_n), 32'd3);
        chk("empty_busy", 32'(busy), 32'd1);
        chk("empty_overrun", 32'(overrun_cnt), 32'd0);

        // Now in ARB with lane 0 newly requesting: stop must veto the pulse
        lane_req = 4'b0001;
        #1;
        chk("arb_late_adv", 32'(lane_adv), 32'd1);
        stop = 1'b1;
        #1;
        chk("stop_arb_adv", 32'(lane_adv), 32'd0);
        cyc();
        stop = 1'b0;
        chk("stop_arb_busy", 32'(busy), 32'd0);

        // Stop during EMIT
        note_ready = 1'b0;
        start      = 1'b1;
        cyc();
        start = 1'b0;
        cycles(5);
        chk("emit2_valid", 32'(note_valid), 32'd1);
        stop       = 1'b1;
        note_ready = 1'b1;
        start      = 1'b1;
        cyc();
        stop = 1'b0; start = 1'b0; note_ready = 1'b0;
        chk("stop_emit_valid", 32'(note_valid), 32'd0);
        chk("stop_emit_busy", 32'(busy), 32'd0);
        tick_n = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (beat_tick) tick_n++;
        end
        chk("idle_silent", 32'(tick_n), 32'd0);
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_idle", 32'(busy), 32'd0);
        cyc();
        chk("start_stop_idle2", 32'(busy), 32'd0);

        // Reset mid-EMIT on lane 2
        lane_req  = 4'b0100;
        lane_data = {8'd0, 8'd108, 8'd0, 8'd0};
        start     = 1'b1;
        cyc();
        start = 1'b0;
        cycles(4);
        chk("rst_arb_adv", 32'(lane_adv), 32'd4);
        cyc();
        chk("rst_emit_lane", 32'(note_lane), 32'd2);
        chk("rst_emit_data", 32'(note_data), 32'd108);
        cycles(4);
        chk("rst_pre_overrun", 32'(overrun_cnt), 32'd1);
        resetn = 1'b0;
        cyc();
        chk_reset_outputs("midrst");
        resetn = 1'b1;
        cycles(6);
        chk("midrst_needs_start", 32'(busy), 32'd0);

        // Saturation over 300+ lost beats
        lane_req  = 4'b0001;
        lane_data = {8'd0, 8'd0, 8'd0, 8'd100};
        start     = 1'b1;
        cyc();
        start = 1'b0;
        cycles(5);
        chk("sat_valid_start", 32'(note_valid), 32'd1);
        cycles(1220);
        chk("sat_overrun", 32'(overrun_cnt), 32'd255);
        chk("sat_valid", 32'(note_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/beatmap_scheduler.md
BEATMAP_SCHEDULER -- requirements
Module: beatmap_scheduler

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: number of note-lane generators; legal range 2..4.
REQ-002 SHALL have parameter BEAT_DIV, default 16'd50000: clocks per beat; legal range 2..65535.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 start  input  1  level/pulse; begins song playback from IDLE.
REQ-006 stop  input  1  level/pulse; ends playback, returns to IDLE.
REQ-007 lane_req  input  NUM_LANES  bit i high = generator i holds a valid note byte.
REQ-008 lane_data  input  8*NUM_LANES  note byte of lane i at bits [8i+7:8i].
REQ-009 lane_adv  output  NUM_LANES  one-hot, one-cycle pulse telling granted generator to advance.
REQ-010 note_valid  output  1  note_lane/note_data hold a note for the consumer.
REQ-011 note_ready  input  1  consumer accepts note when high with note_valid.
REQ-012 note_lane  output  2  lane index of current note.
REQ-013 note_data  output  8  captured note byte.
REQ-014 beat_tick  output  1  one-cycle pulse per beat while running.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 overrun_cnt  output  8  saturating count of beats lost to backpressure.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_BEAT, ARB, EMIT.
REQ-018 16-bit beat counter SHALL count 0..BEAT_DIV-1 and wrap to 0 in every non-IDLE state; held at 0 in IDLE.
REQ-019 beat_tick SHALL pulse for exactly one cycle in the cycle the counter equals BEAT_DIV-1.
REQ-020 IDLE -> WAIT_BEAT when start=1 and stop=0; start SHALL clear overrun_cnt and reset the round-robin pointer to lane 0.
REQ-021 WAIT_BEAT -> ARB on the cycle beat_tick=1.
REQ-022 ARB SHALL last one cycle: round-robin search of lane_req beginning at (last_grant+1) mod NUM_LANES, with pointer initial value placing lane 0 first after start.
REQ-023 ARB with a winner SHALL, in that same cycle, pulse lane_adv[winner], and on the next edge register note_data=lane_data[winner], note_lane=winner, last_grant=winner, note_valid=1, and enter EMIT.
REQ-024 ARB with no lane_req bit set SHALL return to WAIT_BEAT with no lane_adv pulse and no overrun increment.
REQ-025 EMIT SHALL hold note_valid, note_lane, note_data stable until note_ready=1; on that edge note_valid=0 and the FSM enters WAIT_BEAT.
REQ-026 At most one note SHALL be granted per beat; beats are never queued.
REQ-027 beat_tick occurring while in EMIT (including the cycle note_ready=1) SHALL increment overrun_cnt, saturating at 255; that beat is discarded.
REQ-028 stop=1 in any state SHALL force IDLE on the next edge, clear note_valid, suppress lane_adv in that cycle; stop has priority over start and note_ready.
REQ-029 lane_adv SHALL be all-zero outside ARB-with-winner cycles; never more than one bit high.
REQ-030 note_lane for NUM_LANES<4 SHALL only take values 0..NUM_LANES-1.

Reset
REQ-031 With resetn=0 at a rising edge: state=IDLE, beat counter=0, last_grant=NUM_LANES-1, note_valid=0, note_lane=0, note_data=8'd0, lane_adv=0, beat_tick=0, busy=0, overrun_cnt=0.
REQ-032 Reset asserted mid-EMIT SHALL drop note_valid at that edge with no lane_adv pulse; start is required to resume.

Verification (BEAT_DIV=4, NUM_LANES=4)
REQ-033 start pulse, lane_req=4'b0001, lane_data[7:0]=8'd100, note_ready=1 -> beat_tick every 4 clocks; lane_adv=4'b0001 in ARB; note_data=100, note_lane=0 for one cycle per beat.
REQ-034 lane_req=4'b1111, lane bytes 100/104/108/112, note_ready=1 -> grants in order lanes 0,1,2,3,0; note_data 100,104,108,112,100.
REQ-035 lane_req=4'b0001, note_ready=0 for 12 clocks -> note_valid held, note_data stable, overrun_cnt=3 (beats at 4-clock spacing), one lane_adv only; then note_ready=1 -> WAIT_BEAT.
REQ-036 lane_req=0 for 3 beats -> no lane_adv, note_valid stays 0, overrun_cnt=0, busy=1.
REQ-037 stop asserted during EMIT with note_ready=0 -> next edge IDLE, note_valid=0, busy=0, beat_tick silent; start and stop same cycle from IDLE -> stays IDLE.
REQ-038 resetn=0 one cycle during EMIT -> all outputs at REQ-031 values; overrun saturation: hold note_ready=0 for 300 beats -> overrun_cnt=255.
